tetris_game_ctrl: RTL and testbench

Sequencing controller for the 4-column × 8-row Tetris board (32-bit board word). It owns the settled-board and active-piece registers and runs spawn, gravity, lateral moves, lock and row clearing, one full-row removal per cycle. It also keeps the score and flags game over. It sits between the player-input logic and the display/board consumer. It replaces ad-hoc combinational clearing with a clocked, bounded-latency schedule.

---
 rtl/tetris_pkg.sv | 45 ++++
 rtl/tetris_game_ctrl_row_remove.sv | 22 ++
 rtl/tetris_game_ctrl.sv | 188 ++++++++++++++++++
 tb/tb_tetris_game_ctrl.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/tetris_pkg.sv
// Shared types and constants for the 4x8 Tetris sequencing controller.
// Board word layout: row r occupies bits [4r+3:4r]; row 0 is the top/spawn row.
package tetris_pkg;

    localparam int ROWS = 8;
    localparam int COLS = 4;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SPAWN = 3'd1,
        S_FALL  = 3'd2,
        S_LOCK  = 3'd3,
        S_CLEAR = 3'd4,
        S_OVER  = 3'd5
    } state_t;

    // Spawn shapes, all anchored at column 1 of the top row.
    localparam logic [31:0] MASK_SINGLE = 32'h0000_0002;
    localparam logic [31:0] MASK_BAR2   = 32'h0000_0006;
    localparam logic [31:0] MASK_SQUARE = 32'h0000_0066;
    localparam logic [31:0] MASK_ELL    = 32'h0000_0062;

    // Column 0 and column 3 of every row, used for wall checks on lateral moves.
    localparam logic [31:0] COL0_MASK = 32'h1111_1111;
    localparam logic [31:0] COL3_MASK = 32'h8888_8888;

    // True when every cell of row r is occupied.
    function automatic logic row_full(input logic [31:0] board, input logic [2:0] r);
        return &board[{r, 2'b00} +: COLS];
    endfunction

    // Piece mask for a given shape selector.
    function automatic logic [31:0] spawn_mask(input logic [1:0] sel);
        logic [31:0] m;
        case (sel)
            2'b00:   m = MASK_SINGLE;
            2'b01:   m = MASK_BAR2;
            2'b10:   m = MASK_SQUARE;
            2'b11:   m = MASK_ELL;
            default: m = MASK_SINGLE;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/tetris_game_ctrl_row_remove.sv
// Removes one row from the board: rows above it drop by one, the top row refills empty.
module row_remove
    import tetris_pkg::*;
(
    input  logic [31:0] board,
    input  logic [2:0]  r,
    output logic [31:0] shifted
);

    // Rows below r keep their place; rows at or above r take the row one higher up.
    always_comb begin
        shifted = 32'h0000_0000;
        for (int i = 1; i < ROWS; i++) begin
            if (3'(i) > r) begin
                shifted[4*i +: 4] = board[4*i +: 4];
            end else begin
                shifted[4*i +: 4] = board[4*(i-1) +: 4];
            end
        end
    end

endmodule

// File: rtl/tetris_game_ctrl.sv
// Tetris sequencing controller: owns the settled board, active piece, gravity
// counter and score, and schedules spawn / fall / lock / one-row-per-cycle clearing.
module tetris_game_ctrl
    import tetris_pkg::*;
#(
    parameter int DROP_TICKS = 16,
    parameter int SCORE_W    = 8
) (
    input  logic               clka,
    input  logic               rst_n,
    input  logic               start,
    input  logic               move_left,
    input  logic               move_right,
    input  logic [1:0]         piece_sel,
    output logic [31:0]        board_out,
    output logic [2:0]         state,
    output logic [SCORE_W-1:0] score,
    output logic               line_pulse,
    output logic               game_over
);

    localparam int CNT_W = $clog2(DROP_TICKS);
    localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(DROP_TICKS - 1);
    localparam logic [SCORE_W-1:0] SCORE_MAX = {SCORE_W{1'b1}};

    state_t             state_r, state_n;
    logic [31:0]        board_r, board_n;
    logic [31:0]        piece_r, piece_n;
    logic [SCORE_W-1:0] score_r, score_n;
    logic [CNT_W-1:0]   cnt_r, cnt_n;
    logic               pulse_r, pulse_n;
    logic               over_r;

    logic [31:0] mask_s;
    logic [31:0] cleared_s;
    logic        full_found_s;
    logic [2:0]  full_row_s;
    logic        tick_s;
    logic        down_blocked_s;
    logic        left_ok_s;
    logic        right_ok_s;

    assign mask_s         = spawn_mask(piece_sel);
    assign tick_s         = (cnt_r == TICK_LAST);
    assign down_blocked_s = (piece_r[31:28] != 4'b0000) ||
                            (({piece_r[27:0], 4'b0000} & board_r) != 32'h0000_0000);
    assign left_ok_s      = ((piece_r & COL0_MASK) == 32'h0000_0000) &&
                            (({1'b0, piece_r[31:1]} & board_r) == 32'h0000_0000);
    assign right_ok_s     = ((piece_r & COL3_MASK) == 32'h0000_0000) &&
                            (({piece_r[30:0], 1'b0} & board_r) == 32'h0000_0000);

    // Priority encoder: the last full row seen in the ascending scan is the lowest on screen.
    always_comb begin
        full_found_s = 1'b0;
        full_row_s   = 3'd0;
        for (int i = 0; i < ROWS; i++) begin
            if (row_full(board_r, 3'(i))) begin
                full_found_s = 1'b1;
                full_row_s   = 3'(i);
            end else begin
                full_found_s = full_found_s;
                full_row_s   = full_row_s;
            end
        end
    end

    row_remove u_row_remove (
        .board   (board_r),
        .r       (full_row_s),
        .shifted (cleared_s)
    );

    // Next-state and datapath update for every FSM state.
    always_comb begin
        state_n = state_r;
        board_n = board_r;
        piece_n = piece_r;
        score_n = score_r;
        cnt_n   = cnt_r;
        pulse_n = 1'b0;
        case (state_r)
            S_IDLE: begin
                board_n = 32'h0000_0000;
                piece_n = 32'h0000_0000;
                score_n = '0;
                cnt_n   = '0;
                if (start) begin
                    state_n = S_SPAWN;
                end else begin
                    state_n = S_IDLE;
                end
            end
            S_SPAWN: begin
                // The piece loads even on overlap so the collision stays visible in OVER.
                piece_n = mask_s;
                cnt_n   = '0;
                if ((mask_s & board_r) != 32'h0000_0000) begin
                    state_n = S_OVER;
                end else begin
                    state_n = S_FALL;
                end
            end
            S_FALL: begin
                if (tick_s) begin
                    cnt_n = '0;
                    if (down_blocked_s) begin
                        state_n = S_LOCK;
                    end else begin
                        piece_n = {piece_r[27:0], 4'b0000};
                    end
                end else begin
                    cnt_n = cnt_r + CNT_W'(1);
                    if (move_left && !move_right && left_ok_s) begin
                        piece_n = {1'b0, piece_r[31:1]};
                    end else if (move_right && !move_left && right_ok_s) begin
                        piece_n = {piece_r[30:0], 1'b0};
                    end else begin
                        piece_n = piece_r;
                    end
                end
            end
            S_LOCK: begin
                board_n = board_r | piece_r;
                piece_n = 32'h0000_0000;
                state_n = S_CLEAR;
            end
            S_CLEAR: begin
                if (full_found_s) begin
                    board_n = cleared_s;
                    pulse_n = 1'b1;
                    if (score_r != SCORE_MAX) begin
                        score_n = score_r + SCORE_W'(1);
                    end else begin
                        score_n = score_r;
                    end
                end else begin
                    state_n = S_SPAWN;
                end
            end
            S_OVER: begin
                if (start) begin
                    board_n = 32'h0000_0000;
                    piece_n = 32'h0000_0000;
                    score_n = '0;
                    cnt_n   = '0;
                    state_n = S_SPAWN;
                end else begin
                    state_n = S_OVER;
                end
            end
            default: begin
                state_n = S_IDLE;
                board_n = 32'h0000_0000;
                piece_n = 32'h0000_0000;
                score_n = '0;
                cnt_n   = '0;
            end
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clka) begin
        if (!rst_n) begin
            state_r <= S_IDLE;
            board_r <= 32'h0000_0000;
            piece_r <= 32'h0000_0000;
            score_r <= '0;
            cnt_r   <= '0;
            pulse_r <= 1'b0;
            over_r  <= 1'b0;
        end else begin
            state_r <= state_n;
            board_r <= board_n;
            piece_r <= piece_n;
            score_r <= score_n;
            cnt_r   <= cnt_n;
            pulse_r <= pulse_n;
            over_r  <= (state_n == S_OVER);
        end
    end

    assign board_out  = board_r | piece_r;
    assign state      = state_r;
    assign score      = score_r;
    assign line_pulse = pulse_r;
    assign game_over  = over_r;

endmodule

// File: tb/tb_tetris_game_ctrl.sv
// Directed scoreboard bench for tetris_game_ctrl with a short gravity period.
module tb_tetris_game_ctrl;
    import tetris_pkg::*;

    localparam int DT = 4;

    logic        clka = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        move_left = 1'b0;
    logic        move_right = 1'b0;
    logic [1:0]  piece_sel = 2'b00;
    logic [31:0] board_out;
    logic [2:0]  state;
    logic [7:0]  score;
    logic        line_pulse;
    logic        game_over;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       tag;
        logic [31:0] exp;
    } exp_t;
    exp_t sb[$];

    tetris_game_ctrl #(.DROP_TICKS(DT), .SCORE_W(8)) dut (
        .clka       (clka),
        .rst_n      (rst_n),
        .start      (start),
        .move_left  (move_left),
        .move_right (move_right),
        .piece_sel  (piece_sel),
        .board_out  (board_out),
        .state      (state),
        .score      (score),
        .line_pulse (line_pulse),
        .game_over  (game_over)
    );

    always #5 clka = ~clka;

    task automatic step(input int n);
        repeat (n) @(posedge clka);
        #1;
    endtask

    task automatic push(input string tag, input logic [31:0] exp);
        exp_t e;
        e.tag = tag;
        e.exp = exp;
        sb.push_back(e);
    endtask

    task automatic pop_cmp(input logic [31:0] obs);
        exp_t e;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $error("FAIL scoreboard_empty observed=%h expected=queued_entry", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.exp) else begin
                errors++;
                $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.exp);
            end
        end
    endtask

    task automatic wait_state(input string tag, input logic [2:0] s, input int budget);
        int n = 0;
        push(tag, {29'd0, s});
        while (state !== s && n < budget) begin
            step(1);
            n++;
        end
        pop_cmp({29'd0, state});
    endtask

    // dir: 0 none, 1 left, 2 right; moves held for nmov cycles from the first FALL cycle
    task automatic drop(input logic [1:0] sel, input int dir, input int nmov);
        wait_state("await_spawn", S_SPAWN, 200);
        piece_sel = sel;
        step(1);
        move_left  = (dir == 1);
        move_right = (dir == 2);
        step(nmov);
        move_left  = 1'b0;
        move_right = 1'b0;
        wait_state("await_lock", S_LOCK, 100);
    endtask

    initial begin
        int pulses;

        // Reset values
        rst_n = 1'b0;
        push("rst_state", 32'(S_IDLE));
        push("rst_board", 32'h0000_0000);
        push("rst_score", 32'h0000_0000);
        push("rst_pulse", 32'h0000_0000);
        push("rst_over", 32'h0000_0000);
        step(2);
        pop_cmp({29'd0, state});
        pop_cmp(board_out);
        pop_cmp({24'd0, score});
        pop_cmp({31'd0, line_pulse});
        pop_cmp({31'd0, game_over});

        // Game A: single piece falls the full column
        rst_n = 1'b1;
        start = 1'b1;
        piece_sel = 2'b00;
        push("start_to_spawn", 32'(S_SPAWN));
        push("spawn_board_empty", 32'h0000_0000);
        step(1);
        pop_cmp({29'd0, state});
        pop_cmp(board_out);
        start = 1'b0;

        push("single_spawned", 32'h0000_0002);
        push("fall_state", 32'(S_FALL));
        step(1);
        pop_cmp(board_out);
        pop_cmp({29'd0, state});

        move_left = 1'b1;
        move_right = 1'b1;
        push("both_moves_1", 32'h0000_0002);
        step(1);
        pop_cmp(board_out);
        push("both_moves_2", 32'h0000_0002);
        step(1);
        pop_cmp(board_out);
        move_left = 1'b0;
        move_right = 1'b0;

        push("pre_tick", 32'h0000_0002);
        step(1);
        pop_cmp(board_out);
        push("first_gravity", 32'h0000_0020);
        step(1);
        pop_cmp(board_out);
        push("seven_ticks_bit29", 32'h2000_0000);
        step(6 * DT);
        pop_cmp(board_out);
        push("bottom_still_fall", 32'(S_FALL));
        step(DT - 1);
        pop_cmp({29'd0, state});
        push("lock_on_tick", 32'(S_LOCK));
        step(1);
        pop_cmp({29'd0, state});
        push("clear_state", 32'(S_CLEAR));
        push("locked_board", 32'h2000_0000);
        step(1);
        pop_cmp({29'd0, state});
        pop_cmp(board_out);

        // Square spawn, then move right: first succeeds, second hits the wall
        piece_sel = 2'b10;
        push("respawn_latency", 32'(S_SPAWN));
        step(1);
        pop_cmp({29'd0, state});
        push("square_spawned", 32'h2000_0066);
        step(1);
        pop_cmp(board_out);
        piece_sel = 2'b11;
        move_right = 1'b1;
        push("square_right", 32'h2000_00CC);
        step(1);
        pop_cmp(board_out);
        push("square_right_blocked", 32'h2000_00CC);
        step(1);
        pop_cmp(board_out);
        move_right = 1'b0;

        // Game B: build rows 7 and 6 to complete on one lock, with col 0 above
        rst_n = 1'b0;
        step(1);
        rst_n = 1'b1;
        start = 1'b1;
        step(1);
        start = 1'b0;
        for (int i = 0; i < 3; i++) drop(2'b00, 1, 1);
        for (int i = 0; i < 2; i++) drop(2'b00, 2, 2);
        drop(2'b10, 0, 0);
        push("double_full_board", 32'hFF10_0000);
        pop_cmp(board_out);

        pulses = 0;
        push("clear_pulses", 32'd2);
        push("lock_to_spawn_4", 32'(S_SPAWN));
        push("clear_score", 32'd2);
        push("clear_board", 32'h1000_0000);
        for (int i = 0; i < 4; i++) begin
            step(1);
            pulses += int'(line_pulse);
        end
        pop_cmp(32'(pulses));
        pop_cmp({29'd0, state});
        pop_cmp({24'd0, score});
        pop_cmp(board_out);

        // Stack column 1 to the top, then the next spawn collides
        for (int i = 0; i < 8; i++) drop(2'b00, 0, 0);
        wait_state("final_spawn", S_SPAWN, 200);
        piece_sel = 2'b00;
        push("over_state", 32'(S_OVER));
        push("over_flag", 32'd1);
        push("over_board", 32'h3222_2222);
        push("over_score", 32'd2);
        step(1);
        pop_cmp({29'd0, state});
        pop_cmp({31'd0, game_over});
        pop_cmp(board_out);
        pop_cmp({24'd0, score});

        push("over_held", 32'(S_OVER));
        step(2);
        pop_cmp({29'd0, state});

        start = 1'b1;
        push("restart_spawn", 32'(S_SPAWN));
        push("restart_board", 32'h0000_0000);
        push("restart_score", 32'd0);
        push("restart_over_low", 32'd0);
        step(1);
        start = 1'b0;
        pop_cmp({29'd0, state});
        pop_cmp(board_out);
        pop_cmp({24'd0, score});
        pop_cmp({31'd0, game_over});
        push("restart_piece", 32'h0000_0002);
        step(1);
        pop_cmp(board_out);

        // Reset while in CLEAR discards everything
        wait_state("await_lock_c", S_LOCK, 100);
        push("clear_before_rst", 32'(S_CLEAR));
        push("board_before_rst", 32'h2000_0000);
        step(1);
        pop_cmp({29'd0, state});
        pop_cmp(board_out);
        rst_n = 1'b0;
        push("rst_clear_state", 32'(S_IDLE));
        push("rst_clear_board", 32'h0000_0000);
        push("rst_clear_score", 32'd0);
        push("rst_clear_pulse", 32'd0);
        push("rst_clear_over", 32'd0);
        step(1);
        pop_cmp({29'd0, state});
        pop_cmp(board_out);
        pop_cmp({24'd0, score});
        pop_cmp({31'd0, line_pulse});
        pop_cmp({31'd0, game_over});
        rst_n = 1'b1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
